// File: rtl/pte_port_pkg.sv
// Shared types and widths for the MMU page-walk DRAM port.
package pte_port_pkg;

  localparam int unsigned PTE_WIDTH = 32;
  localparam int unsigned PTE_V_BIT = 0;
  localparam int unsigned TMO_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } pw_state_e;

  // Latched MMU command, replayed to DRAM.
  typedef struct packed {
    logic                 we;
    logic [PTE_WIDTH-1:0] addr;
    logic [PTE_WIDTH-1:0] wdata;
  } pte_cmd_t;

endpackage

// File: rtl/m_pte_dram_port_if.sv
// MMU-side and DRAM-side signals of the page-walk port.
interface m_pte_dram_port_if;
  import pte_port_pkg::*;

  logic                 i_req;
  logic                 i_we;
  logic [PTE_WIDTH-1:0] i_addr;
  logic [PTE_WIDTH-1:0] i_wdata;
  logic                 i_flush;
  logic                 o_busy;
  logic [PTE_WIDTH-1:0] o_rdata;
  logic                 o_err;
  logic                 o_dram_req;
  logic                 o_dram_we;
  logic [PTE_WIDTH-1:0] o_dram_addr;
  logic [PTE_WIDTH-1:0] o_dram_wdata;
  logic                 i_dram_busy;
  logic                 i_dram_done;
  logic [PTE_WIDTH-1:0] i_dram_rdata;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_flush,
    input  i_dram_busy, i_dram_done, i_dram_rdata,
    output o_busy, o_rdata, o_err,
    output o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_flush,
    output i_dram_busy, i_dram_done, i_dram_rdata,
    input  o_busy, o_rdata, o_err,
    input  o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata
  );

endinterface

// File: rtl/m_pw_timeout.sv
// Saturating WAIT-cycle counter; expire_c flags the last allowed cycle.
module m_pw_timeout
  import pte_port_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [TMO_WIDTH-1:0] limit,
  output logic                 expire_c
);

  localparam int unsigned CW = TMO_WIDTH + 1;

  logic [TMO_WIDTH-1:0] cnt;

  // Count enabled cycles, clear on request, hold at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt < limit)) begin
      cnt <= cnt + TMO_WIDTH'(1);
    end
  end

  // The cycle whose edge takes the count to the limit is the expiring one.
  assign expire_c = en && (({1'b0, cnt} + CW'(1)) >= {1'b0, limit});

endmodule

// File: rtl/m_pte_dram_port.sv
// Page-walk memory port: sequences MMU PTE reads/write-backs onto DRAM.
// Optional one-entry PTE cache enabled by defining PTE_L1_CACHE_EN.
module m_pte_dram_port
  import pte_port_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic             CLK,
  input  logic             RST_X,
  m_pte_dram_port_if.slave bus
);

  localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = TMO_WIDTH'(TIMEOUT_CYCLES);

  pw_state_e            state;
  pte_cmd_t             cmd_q;
  logic [PTE_WIDTH-1:0] req_addr_c;
  logic                 issue_c;
  logic                 wait_c;
  logic                 tmo_expire_c;
  logic                 hit_c;
  logic [PTE_WIDTH-1:0] hit_data_c;

  assign req_addr_c = {bus.i_addr[PTE_WIDTH-1:2], 2'b00};
  // The strobe must follow DRAM busy in the same cycle, so it is decoded.
  assign issue_c    = (state == ISSUE) && !bus.i_dram_busy;
  assign wait_c     = (state == WAIT);

  assign bus.o_dram_req   = issue_c;
  assign bus.o_dram_we    = cmd_q.we;
  assign bus.o_dram_addr  = cmd_q.addr;
  assign bus.o_dram_wdata = cmd_q.wdata;

  m_pw_timeout u_timeout (
    .clk      (CLK),
    .rst_n    (RST_X),
    .clr      (issue_c),
    .en       (wait_c),
    .limit    (TMO_LIMIT),
    .expire_c (tmo_expire_c)
  );

`ifdef PTE_L1_CACHE_EN
  logic                 c_valid;
  logic [PTE_WIDTH-1:0] c_addr;
  logic [PTE_WIDTH-1:0] c_data;
  logic                 c_match_c;

  assign c_match_c  = c_valid && (c_addr == req_addr_c);
  assign hit_c      = (state == IDLE) && bus.i_req && !bus.i_we && c_match_c;
  assign hit_data_c = c_data;

  // One-entry PTE cache: fill on DRAM read, write-through, flush wins.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      c_valid <= 1'b0;
      c_addr  <= '0;
      c_data  <= '0;
    end else begin
      if ((state == IDLE) && bus.i_req && bus.i_we && c_match_c) begin
        c_data <= bus.i_wdata;
      end
      if (wait_c && bus.i_dram_done && !cmd_q.we) begin
        c_valid <= 1'b1;
        c_addr  <= cmd_q.addr;
        c_data  <= bus.i_dram_rdata;
      end
      if (bus.i_flush) begin
        c_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_flush;
  assign unused_flush = bus.i_flush;
  assign hit_c        = 1'b0;
  assign hit_data_c   = '0;
`endif

  // Access sequencer with registered busy, read data and error pulse.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state       <= IDLE;
      cmd_q       <= '0;
      bus.o_busy  <= 1'b0;
      bus.o_rdata <= '0;
      bus.o_err   <= 1'b0;
    end else begin
      bus.o_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req) begin
            cmd_q.we    <= bus.i_we;
            cmd_q.addr  <= req_addr_c;
            cmd_q.wdata <= bus.i_wdata;
            if (hit_c) begin
              bus.o_rdata <= hit_data_c;
              state       <= DONE;
            end else begin
              bus.o_busy <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!bus.i_dram_busy) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.i_dram_done) begin
            if (!cmd_q.we) begin
              bus.o_rdata <= bus.i_dram_rdata;
            end
            bus.o_busy <= 1'b0;
            state      <= DONE;
          end else if (tmo_expire_c) begin
            bus.o_rdata <= '0;
            bus.o_err   <= 1'b1;
            bus.o_busy  <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_pte_dram_port.sv
// Self-checking bench for m_pte_dram_port (TIMEOUT_CYCLES = 8).
module tb_m_pte_dram_port;
  import pte_port_pkg::*;

  localparam int unsigned TMO = 8;

  logic CLK;
  logic RST_X;

  m_pte_dram_port_if bus ();

  m_pte_dram_port #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] model_rdata = '0;

  // Observations returned by the access driver.
  int          o_strobes, o_strobe_cyc, o_end_cyc, o_err_cyc;
  logic [31:0] o_s_addr, o_s_wdata, o_rd;
  logic        o_s_we;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req        = 1'b0;
    bus.i_we         = 1'b0;
    bus.i_addr       = '0;
    bus.i_wdata      = '0;
    bus.i_flush      = 1'b0;
    bus.i_dram_busy  = 1'b0;
    bus.i_dram_done  = 1'b0;
    bus.i_dram_rdata = '0;
  endtask

  // Drives one access cycle by cycle. Cycle 0 presents the request; in each
  // later cycle the DRAM inputs are set first, then outputs are observed.
  // done_after < 0 means DRAM never answers.
  task automatic access(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int busy_cyc,
                        input int done_after, input logic [31:0] drdata);
    int c;
    bit fin;
    o_strobes = 0; o_strobe_cyc = -1; o_end_cyc = -1; o_err_cyc = -1;
    o_s_addr = '0; o_s_wdata = '0; o_s_we = 1'b0; o_rd = '0;
    bus.i_req = 1'b1; bus.i_we = we; bus.i_addr = addr; bus.i_wdata = wdata;
    tick();
    bus.i_req = 1'b0;
    c = 1;
    fin = 1'b0;
    while (!fin && c < 200) begin
      bus.i_dram_busy  = (c <= busy_cyc);
      bus.i_dram_done  = (done_after >= 0) && (o_strobe_cyc >= 0) &&
                         (c == o_strobe_cyc + done_after);
      bus.i_dram_rdata = drdata;
      #1;
      if (bus.o_dram_req === 1'b1) begin
        o_strobes++;
        o_strobe_cyc = c;
        o_s_addr  = bus.o_dram_addr;
        o_s_we    = bus.o_dram_we;
        o_s_wdata = bus.o_dram_wdata;
      end
      if (bus.o_err === 1'b1) o_err_cyc = c;
      if (bus.o_busy === 1'b0) begin
        fin = 1'b1;
        o_end_cyc = c;
        o_rd = bus.o_rdata;
      end else begin
        tick();
        c++;
      end
    end
    idle_inputs();
    if (!fin) begin
      vec_cnt++; err_cnt++;
      $display("FAIL access_bound: no completion in 200 cycles addr=%h", addr);
    end
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    RST_X = 1'b0;
    tick(); tick();
    vec_cnt++;
    if ({bus.o_busy, bus.o_err, bus.o_dram_req, bus.o_dram_we} !== 4'b0)
      begin err_cnt++; $display("FAIL reset_flags: got %b want 0000",
        {bus.o_busy, bus.o_err, bus.o_dram_req, bus.o_dram_we}); end
    vec_cnt++;
    if (bus.o_rdata !== 32'h0)
      begin err_cnt++; $display("FAIL reset_rdata: got %h want 0", bus.o_rdata); end
    vec_cnt++;
    if ({bus.o_dram_addr, bus.o_dram_wdata} !== 64'h0)
      begin err_cnt++; $display("FAIL reset_dram_bus: got %h/%h want 0",
        bus.o_dram_addr, bus.o_dram_wdata); end
    RST_X = 1'b1;
    tick();
  endtask

  task automatic test_read();
    exp_t e;
    exp_q.push_back('{rdata: 32'h2000_0401, err: 1'b0});
    model_rdata = 32'h2000_0401;
    access(1'b0, 32'h8000_1003, 32'h0, 0, 2, 32'h2000_0401);
    e = exp_q.pop_front();
    vec_cnt++;
    if (o_rd !== e.rdata || (o_err_cyc >= 0) !== e.err)
      begin err_cnt++; $display("FAIL read_data: got %h err=%0b want %h err=%0b",
        o_rd, o_err_cyc >= 0, e.rdata, e.err); end
    vec_cnt++;
    if (o_s_addr !== 32'h8000_1000 || o_s_we !== 1'b0)
      begin err_cnt++; $display("FAIL read_cmd: addr %h we %b want 80001000 we 0",
        o_s_addr, o_s_we); end
    vec_cnt++;
    if (o_strobes !== 1 || o_strobe_cyc !== 1 || o_end_cyc !== 4)
      begin err_cnt++; $display("FAIL read_timing: strobes %0d at %0d end %0d want 1 at 1 end 4",
        o_strobes, o_strobe_cyc, o_end_cyc); end
  endtask

  task automatic test_write();
    exp_t e;
    exp_q.push_back('{rdata: model_rdata, err: 1'b0});
    access(1'b1, 32'h8000_2000, 32'h0000_00CF, 0, 2, 32'hDEAD_BEEF);
    e = exp_q.pop_front();
    vec_cnt++;
    if (o_rd !== e.rdata)
      begin err_cnt++; $display("FAIL write_rdata_hold: got %h want %h", o_rd, e.rdata); end
    vec_cnt++;
    if (o_strobes !== 1 || o_s_we !== 1'b1 || o_s_wdata !== 32'hCF ||
        o_s_addr !== 32'h8000_2000)
      begin err_cnt++; $display("FAIL write_cmd: n=%0d we=%b wd=%h a=%h want 1 1 cf 80002000",
        o_strobes, o_s_we, o_s_wdata, o_s_addr); end
  endtask

  task automatic test_dram_busy();
    exp_t e;
    exp_q.push_back('{rdata: 32'h3000_0001, err: 1'b0});
    model_rdata = 32'h3000_0001;
    access(1'b0, 32'h8000_3008, 32'h0, 5, 2, 32'h3000_0001);
    e = exp_q.pop_front();
    vec_cnt++;
    if (o_strobes !== 1 || o_strobe_cyc !== 6 || o_end_cyc !== 9)
      begin err_cnt++; $display("FAIL busy_hold: strobes %0d at %0d end %0d want 1 at 6 end 9",
        o_strobes, o_strobe_cyc, o_end_cyc); end
    vec_cnt++;
    if (o_rd !== e.rdata)
      begin err_cnt++; $display("FAIL busy_data: got %h want %h", o_rd, e.rdata); end
  endtask

  task automatic test_timeout();
    exp_t e;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    model_rdata = 32'h0;
    access(1'b0, 32'h8000_4000, 32'h0, 0, -1, 32'h0);
    e = exp_q.pop_front();
    vec_cnt++;
    if (o_err_cyc !== int'(2 + TMO) || o_end_cyc !== int'(2 + TMO))
      begin err_cnt++; $display("FAIL tmo_cycle: err at %0d end %0d want %0d",
        o_err_cyc, o_end_cyc, 2 + TMO); end
    vec_cnt++;
    if (o_rd !== e.rdata || o_rd[PTE_V_BIT] !== 1'b0)
      begin err_cnt++; $display("FAIL tmo_rdata: got %h want %h", o_rd, e.rdata); end
    // Now in IDLE: the error pulse is gone; a late completion must be ignored.
    vec_cnt++;
    if (bus.o_err !== 1'b0)
      begin err_cnt++; $display("FAIL tmo_pulse_width: o_err %b want 0", bus.o_err); end
    bus.i_dram_done = 1'b1; bus.i_dram_rdata = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    tick();
    vec_cnt++;
    if (bus.o_rdata !== 32'h0 || bus.o_busy !== 1'b0 || bus.o_err !== 1'b0)
      begin err_cnt++; $display("FAIL tmo_late_done: rdata %h busy %b err %b want 0 0 0",
        bus.o_rdata, bus.o_busy, bus.o_err); end
    exp_q.push_back('{rdata: 32'h4000_0001, err: 1'b0});
    model_rdata = 32'h4000_0001;
    access(1'b0, 32'h8000_4000, 32'h0, 0, 3, 32'h4000_0001);
    e = exp_q.pop_front();
    vec_cnt++;
    if (o_rd !== e.rdata || o_err_cyc !== -1 || o_end_cyc !== 5)
      begin err_cnt++; $display("FAIL tmo_recover: got %h err@%0d end %0d want %h none 5",
        o_rd, o_err_cyc, o_end_cyc, e.rdata); end
  endtask

  task automatic test_cache();
    exp_t e;
    exp_q.push_back('{rdata: 32'h5000_0001, err: 1'b0});
    access(1'b0, 32'h8000_5000, 32'h0, 0, 2, 32'h5000_0001);
    e = exp_q.pop_front();
    vec_cnt++;
    if (o_rd !== e.rdata || o_strobes !== 1)
      begin err_cnt++; $display("FAIL cache_fill: got %h n=%0d want %h n=1",
        o_rd, o_strobes, e.rdata); end
`ifdef PTE_L1_CACHE_EN
    exp_q.push_back('{rdata: 32'h5000_0001, err: 1'b0});
    access(1'b0, 32'h8000_5002, 32'h0, 0, 2, 32'hBAD0_0000);
    e = exp_q.pop_front();
    vec_cnt++;
    if (o_rd !== e.rdata || o_strobes !== 0 || o_end_cyc !== 1)
      begin err_cnt++; $display("FAIL cache_hit: got %h n=%0d end %0d want %h n=0 end 1",
        o_rd, o_strobes, o_end_cyc, e.rdata); end
    access(1'b1, 32'h8000_5000, 32'h5000_00C1, 0, 2, 32'h0);
    vec_cnt++;
    if (o_strobes !== 1 || o_rd !== 32'h5000_0001)
      begin err_cnt++; $display("FAIL cache_wr_through: n=%0d rdata %h want 1 50000001",
        o_strobes, o_rd); end
    exp_q.push_back('{rdata: 32'h5000_00C1, err: 1'b0});
    access(1'b0, 32'h8000_5000, 32'h0, 0, 2, 32'hBAD0_0000);
    e = exp_q.pop_front();
    vec_cnt++;
    if (o_rd !== e.rdata || o_strobes !== 0)
      begin err_cnt++; $display("FAIL cache_wr_update: got %h n=%0d want %h n=0",
        o_rd, o_strobes, e.rdata); end
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    exp_q.push_back('{rdata: 32'h5000_0003, err: 1'b0});
    model_rdata = 32'h5000_0003;
`else
    exp_q.push_back('{rdata: 32'h5000_0003, err: 1'b0});
    model_rdata = 32'h5000_0003;
`endif
    access(1'b0, 32'h8000_5000, 32'h0, 0, 2, 32'h5000_0003);
    e = exp_q.pop_front();
    vec_cnt++;
    if (o_rd !== e.rdata || o_strobes !== 1 || o_end_cyc !== 4)
      begin err_cnt++; $display("FAIL cache_miss_path: got %h n=%0d end %0d want %h n=1 end 4",
        o_rd, o_strobes, o_end_cyc, e.rdata); end
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 32'h8000_6000;
    tick();
    bus.i_req = 1'b0;
    tick();
    tick();
    RST_X = 1'b0;
    #1;
    vec_cnt++;
    if ({bus.o_busy, bus.o_err, bus.o_dram_req} !== 3'b0 || bus.o_rdata !== 32'h0 ||
        bus.o_dram_addr !== 32'h0)
      begin err_cnt++; $display("FAIL rst_wait_outputs: busy %b err %b req %b rd %h a %h want 0",
        bus.o_busy, bus.o_err, bus.o_dram_req, bus.o_rdata, bus.o_dram_addr); end
    tick();
    idle_inputs();
    RST_X = 1'b1;
    model_rdata = 32'h0;
    tick();
    bus.i_dram_done = 1'b1; bus.i_dram_rdata = 32'h6666_0001;
    tick();
    idle_inputs();
    tick();
    vec_cnt++;
    if (bus.o_rdata !== model_rdata || bus.o_busy !== 1'b0)
      begin err_cnt++; $display("FAIL rst_late_done: rdata %h busy %b want %h 0",
        bus.o_rdata, bus.o_busy, model_rdata); end
    exp_q.push_back('{rdata: 32'h6000_0001, err: 1'b0});
    access(1'b0, 32'h8000_6000, 32'h0, 0, 2, 32'h6000_0001);
    e = exp_q.pop_front();
    vec_cnt++;
    if (o_rd !== e.rdata || o_strobes !== 1)
      begin err_cnt++; $display("FAIL rst_fresh_read: got %h n=%0d want %h n=1",
        o_rd, o_strobes, e.rdata); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_dram_busy();
    test_timeout();
    test_cache();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/m_pte_dram_port.md
# m_pte_dram_port

Page-walk memory port between the MMU page-walker and the DRAM controller. It accepts single-word PTE reads (L1/L0 fetch) and PTE write-backs (A/D update) from the MMU, sequences each as one DRAM transaction, and returns read data with a busy flag. The busy/data pair follows the MMU's `w_dram_busy`/`w_dram_odata` contract. A bounded DRAM wait converts a hung access into an invalid PTE, so the walker raises a page fault.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1023: maximum cycles in WAIT before the access is aborted; legal range 1..65535.

Ports:
- CLK  in  1  clock; all state on rising edge
- RST_X  in  1  reset, asynchronous, active-low
- i_req  in  1  MMU access strobe, sampled only in IDLE
- i_we  in  1  1 = PTE write-back, 0 = PTE read
- i_addr  in  32  PTE byte address; bits [1:0] forced to 0
- i_wdata  in  32  PTE write data
- i_flush  in  1  TLB flush; also invalidates the PTE cache
- o_busy  out  1  access in progress (MMU `w_dram_busy`)
- o_rdata  out  32  last read PTE (MMU `w_dram_odata`)
- o_err  out  1  one-cycle pulse when an access times out
- o_dram_req  out  1  one-cycle DRAM command strobe
- o_dram_we  out  1  DRAM command is write
- o_dram_addr  out  32  DRAM word address (latched)
- o_dram_wdata  out  32  DRAM write data (latched)
- i_dram_busy  in  1  DRAM cannot accept a command
- i_dram_done  in  1  one-cycle completion pulse, reads and writes
- i_dram_rdata  in  32  read data, valid with i_dram_done

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, i_req=1:
  - Latch we, addr (with [1:0]=0) and wdata.
  - On a cache read hit, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - Hold while i_dram_busy=1.
  - Otherwise pulse o_dram_req with the latched fields, then go to WAIT.
- WAIT:
  - On i_dram_done: reads capture i_dram_rdata into o_rdata; go to DONE.
  - The timeout counter increments each WAIT cycle. On reaching TIMEOUT_CYCLES: o_rdata <= 0 (V=0), pulse o_err, go to DONE.
  - A late i_dram_done arriving after a timeout is ignored.
- DONE: o_busy=0 for one cycle, then IDLE.
- o_busy = 1 in ISSUE and WAIT, 0 in IDLE and DONE.
- o_rdata changes only on read completion, timeout, or cache hit. It holds its value otherwise, including across writes.
- i_req is ignored outside IDLE. The MMU keeps its address stable until o_busy falls.
- i_flush mid-access: the access completes normally and only the cache is invalidated.
- Reset (any state): IDLE, all outputs 0, cache invalid, counter 0. An outstanding DRAM transaction is abandoned; any i_dram_done after reset is ignored.

## Timing
- Request sampled at cycle 0. o_busy=1 at cycle 1, and o_dram_req at cycle 1 if DRAM is idle.
- i_dram_done arrives at cycle n ≥ 2 → DONE at n+1, with o_rdata valid and o_busy=0. IDLE at n+2, where the next i_req may be sampled.
- Minimum DRAM read: 3 cycles from req to data. Cache hit: data and o_busy=0 at cycle 1.
- Timeout: WAIT entered at cycle 2 → DONE at cycle 2+TIMEOUT_CYCLES, with o_err high for that single cycle.
- The counter is 16 bits, saturates at TIMEOUT_CYCLES, and clears on entry to WAIT.

## Configuration
- PTE_L1_CACHE_EN defined:
  - One-entry PTE cache {valid, addr, data}, filled on every successful DRAM read.
  - A read to the cached address is served in IDLE→DONE without any DRAM command.
  - A write to the cached address updates the cached data (write-through); the DRAM write is still issued.
  - i_flush clears valid. If a fill and a flush fall in the same cycle, the flush wins.
  - A timeout never fills the cache.
- Undefined: no cache. Every access goes to DRAM and the hit path is absent.

## Structure
- Shared package `pte_port_pkg`: FSM state encoding, PTE_WIDTH=32, PTE_V_BIT=0, timeout counter width 16.
- Sub-module `m_pw_timeout`: loadable saturating counter with clear, enable and expire flag. Everything else stays in the top module.

## Test plan
- Read addr 0x8000_1003, DRAM done 2 cycles after o_dram_req with rdata 0x2000_0401 → o_dram_addr=0x8000_1000, o_rdata=0x2000_0401, o_busy low 4 cycles after req.
- Write 0x0000_00CF to 0x8000_2000 → one o_dram_req with o_dram_we=1 and wdata 0xCF; o_rdata unchanged.
- i_dram_busy held 5 cycles at ISSUE → o_dram_req delayed until busy drops; exactly one strobe.
- TIMEOUT_CYCLES=8, no i_dram_done → o_err pulse at cycle 10, o_rdata=0; a late done is ignored and the next request works.
- PTE_L1_CACHE_EN: read A twice → second read gives no o_dram_req and o_busy=0 at cycle 1. i_flush, then read A → DRAM access issued.
- RST_X asserted during WAIT → outputs 0 immediately; a following i_dram_done is ignored; a fresh read completes.
